cic_interp: RTL and testbench

CIC_INTERP -- requirements
Module: cic_interp

---
 rtl/cic_pkg.sv | 35 +++
 rtl/cic_interp_integ.sv | 34 +++
 rtl/cic_interp.sv | 151 +++++++++++++++
 tb/tb_cic_interp.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cic_pkg: defaults and width derivations shared by CIC filters.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cic_pkg;

    localparam int DEF_STAGES        = 3;
    localparam int DEF_INTERPOLATION = 10;
    localparam int DEF_IN_WIDTH      = 16;

    // Smallest shift whose power of two covers the gain R^(STAGES-1).
    function automatic int cic_out_shift(input int stages, input int rate);
        longint gain;
        int     shift;
        gain  = 1;
        shift = 0;
        for (int i = 0; i < stages - 1; i++) begin
            gain = gain * longint'(rate);
        end
        for (int b = 0; b < 62; b++) begin
            if ((longint'(1) << b) < gain) begin
                shift = b + 1;
            end
        end
        return shift;
    endfunction

    function automatic int cic_acc_width(input int in_width, input int stages,
                                         input int out_shift);
        return in_width + stages + out_shift;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_interp_integ.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cic_interp_integ: one strobe-enabled wrapping integrator stage.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cic_interp_integ
    import cic_pkg::*;
#(
    parameter int WIDTH = cic_acc_width(DEF_IN_WIDTH, DEF_STAGES,
                                        cic_out_shift(DEF_STAGES, DEF_INTERPOLATION))
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] add_i,
    output logic [WIDTH-1:0] sum_o
);

    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;

    assign sum_d = sum_q + add_i;
    assign sum_o = sum_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q <= '0;
        end else if (en_i) begin
            sum_q <= sum_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cic_interp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cic_interp: CIC interpolator, low-rate combs then high-rate        |
// | zero-stuffed integrators with rounded, saturated output. Rev 1.0   |
// +--------------------------------------------------------------------+
module cic_interp
    import cic_pkg::*;
#(
    parameter int STAGES        = DEF_STAGES,
    parameter int INTERPOLATION = DEF_INTERPOLATION,
    parameter int IN_WIDTH      = DEF_IN_WIDTH,
    parameter int OUT_SHIFT     = cic_out_shift(STAGES, INTERPOLATION),
    parameter int ACC_WIDTH     = cic_acc_width(IN_WIDTH, STAGES, OUT_SHIFT)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                out_strobe,
    output logic                in_strobe,
    input  logic                in_valid,
    input  logic [IN_WIDTH-1:0] in_data,
    output logic [IN_WIDTH-1:0] out_data,
    output logic                underflow,
    input  logic                underflow_clr
);

    localparam int PHASE_W = (INTERPOLATION > 1) ? $clog2(INTERPOLATION) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(INTERPOLATION - 1);
    localparam logic [ACC_WIDTH:0] ROUND_HALF = (ACC_WIDTH + 1)'(1) << (OUT_SHIFT - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH + 1)'((2 ** (IN_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

    logic [PHASE_W-1:0]  phase_q;
    logic [PHASE_W-1:0]  phase_d;
    logic                in_strobe_q;
    logic                in_strobe_d;
    logic                underflow_q;
    logic                underflow_d;
    logic [IN_WIDTH-1:0] out_data_q;
    logic [IN_WIDTH-1:0] out_data_d;

    logic [ACC_WIDTH-1:0] comb_q   [STAGES];
    logic [ACC_WIDTH-1:0] prev_q   [STAGES];
    logic [ACC_WIDTH-1:0] w_comb_in [STAGES];

    logic [STAGES-1:0][ACC_WIDTH-1:0] w_integ_add;
    logic [STAGES-1:0][ACC_WIDTH-1:0] w_integ_sum;

    logic signed [ACC_WIDTH:0] w_round;
    logic signed [ACC_WIDTH:0] w_scaled;
    logic [IN_WIDTH-1:0]       w_sat;

    // Phase and input-request control
    always_comb begin
        phase_d = phase_q;
        if (out_strobe) begin
            phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_W'(1);
        end
        in_strobe_d = out_strobe && (phase_q == PHASE_LAST);
    end

    always_comb begin
        underflow_d = underflow_q;
        if (underflow_clr) begin
            underflow_d = 1'b0;
        end
        if (in_strobe_q && !in_valid) begin
            underflow_d = 1'b1;
        end
    end

    // Comb section runs at the low rate, one stage per in_strobe.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            w_comb_in[i] = '0;
        end
        w_comb_in[0] = in_valid ? {{(ACC_WIDTH - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data}
                                : '0;
        for (int i = 1; i < STAGES; i++) begin
            w_comb_in[i] = comb_q[i-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                comb_q[i] <= '0;
                prev_q[i] <= '0;
            end
        end else if (in_strobe_q) begin
            for (int i = 0; i < STAGES; i++) begin
                comb_q[i] <= w_comb_in[i] - prev_q[i];
                prev_q[i] <= w_comb_in[i];
            end
        end
    end

    // Integrator chain; only phase 0 carries a comb sample, the rest are zero-stuffed.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_integ
            if (gi == 0) begin : g_first
                assign w_integ_add[gi] = (phase_q == '0) ? comb_q[STAGES-1] : '0;
            end else begin : g_chain
                assign w_integ_add[gi] = w_integ_sum[gi-1];
            end

            cic_interp_integ #(
                .WIDTH (ACC_WIDTH)
            ) u_integ (
                .clk_i (clock),
                .rst_i (reset),
                .en_i  (out_strobe),
                .add_i (w_integ_add[gi]),
                .sum_o (w_integ_sum[gi])
            );
        end
    endgenerate

    // Round half-up, scale down, clamp into the output range.
    always_comb begin
        w_round  = $signed({w_integ_sum[STAGES-1][ACC_WIDTH-1], w_integ_sum[STAGES-1]})
                 + $signed(ROUND_HALF);
        w_scaled = w_round >>> OUT_SHIFT;
        w_sat    = w_scaled[IN_WIDTH-1:0];
        if (w_scaled > SAT_MAX) begin
            w_sat = SAT_MAX[IN_WIDTH-1:0];
        end else if (w_scaled < SAT_MIN) begin
            w_sat = SAT_MIN[IN_WIDTH-1:0];
        end
        out_data_d = out_strobe ? w_sat : out_data_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q     <= '0;
            in_strobe_q <= 1'b0;
            underflow_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            phase_q     <= phase_d;
            in_strobe_q <= in_strobe_d;
            underflow_q <= underflow_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_strobe = in_strobe_q;
    assign underflow = underflow_q;
    assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_cic_interp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cic_interp: scoreboard bench with a convolution reference.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_cic_interp;

    localparam int R     = 10;
    localparam int N     = 3;
    localparam int IW    = 16;
    localparam int SH    = 7;
    localparam int AW    = 26;
    localparam int NTAPS = N * (R - 1) + 1;
    // End-to-end delay in out_strobes from a zero-stuffed input slot to out_data.
    localparam int LAT   = 24;

    logic          clock         = 1'b0;
    logic          reset         = 1'b0;
    logic          out_strobe    = 1'b0;
    logic          in_valid      = 1'b0;
    logic [IW-1:0] in_data       = '0;
    logic          underflow_clr = 1'b0;
    logic          in_strobe;
    logic [IW-1:0] out_data;
    logic          underflow;

    cic_interp #(
        .STAGES        (N),
        .INTERPOLATION (R),
        .IN_WIDTH      (IW),
        .OUT_SHIFT     (SH),
        .ACC_WIDTH     (AW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .out_strobe    (out_strobe),
        .in_strobe     (in_strobe),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .out_data      (out_data),
        .underflow     (underflow),
        .underflow_clr (underflow_clr)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    int                     h [NTAPS];
    logic signed [IW-1:0]   xh [$];
    logic signed [IW-1:0]   exp_q [$];
    int                     drv_n = 0;

    logic signed [IW-1:0]   m_out   = '0;
    bit                     m_instb = 1'b0;
    bit                     m_uf    = 1'b0;
    int                     m_n     = 0;
    int                     instb_pulses = 0;

    bit     stats_on  = 1'b0;
    int     st_run    = 0;
    int     st_maxrun = 0;
    int     st_nz     = 0;
    int     st_peak   = 0;
    longint st_sum    = 0;

    function automatic void check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Output = box^N impulse response convolved with the zero-stuffed input stream.
    function automatic logic signed [IW-1:0] model_out(input int n);
        longint              acc;
        longint              v;
        logic signed [AW-1:0] wrapped;
        int                  m;
        acc = 0;
        for (int j = 0; j < NTAPS; j++) begin
            m = n - LAT - j;
            if (m >= R && (m % R) == 0 && (m / R) <= xh.size()) begin
                acc += longint'(h[j]) * longint'(xh[m / R - 1]);
            end
        end
        wrapped = acc[AW-1:0];
        v = longint'(wrapped);
        v = (v + (longint'(1) << (SH - 1))) >>> SH;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return v[IW-1:0];
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            m_out   = '0;
            m_instb = 1'b0;
            m_uf    = 1'b0;
            m_n     = 0;
        end else begin
            check("mon_out_data", $signed(out_data), m_out);
            check("mon_in_strobe", in_strobe, m_instb);
            check("mon_underflow", underflow, m_uf);
            if (in_strobe) instb_pulses++;
            if (underflow_clr) m_uf = 1'b0;
            if (m_instb && !in_valid) m_uf = 1'b1;
            if (out_strobe) begin
                m_n++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL mon_scoreboard: out_strobe with no expected sample (t=%0t)", $time);
                end else begin
                    m_out = exp_q.pop_front();
                end
                m_instb = ((m_n % R) == 0);
            end else begin
                m_instb = 1'b0;
            end
        end
    end

    // Entered and left 2 time units after a rising edge.
    task automatic strobe(input int gap, input logic signed [IW-1:0] nxt,
                          input bit vld, input bit clr_req);
        drv_n++;
        exp_q.push_back(model_out(drv_n));
        out_strobe = 1'b1;
        if ((drv_n % R) == 0) begin
            in_data  = nxt;
            in_valid = vld;
            xh.push_back(vld ? nxt : '0);
        end
        @(posedge clock); #2;
        out_strobe    = 1'b0;
        underflow_clr = ((drv_n % R) == 0) && clr_req;
        if (stats_on) begin
            if (out_data != '0) begin
                st_run++;
                st_nz++;
            end else begin
                st_run = 0;
            end
            if (st_run > st_maxrun) st_maxrun = st_run;
            if (int'($signed(out_data)) > st_peak) st_peak = int'($signed(out_data));
            st_sum += longint'($signed(out_data));
        end
        @(posedge clock); #2;
        underflow_clr = 1'b0;
        repeat (gap - 2) begin
            @(posedge clock); #2;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_out_data", $signed(out_data), 0);
        check("rst_in_strobe", in_strobe, 0);
        check("rst_underflow", underflow, 0);
        xh.delete();
        exp_q.delete();
        drv_n = 0;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    task automatic clr_pulse();
        underflow_clr = 1'b1;
        @(posedge clock); #2;
        underflow_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        for (int j = 0; j < NTAPS; j++) h[j] = 0;
        for (int a = 0; a < R; a++)
            for (int b = 0; b < R; b++)
                for (int c = 0; c < R; c++)
                    h[a + b + c]++;

        #3;
        do_reset();

        // Request cadence: one in_strobe per R out_strobes.
        p0 = instb_pulses;
        for (int i = 0; i < 30; i++) strobe(3, 16'sd0, 1'b1, 1'b0);
        check("in_strobe_count_30", instb_pulses - p0, 3);

        // DC gain
        for (int i = 0; i < 80; i++) strobe($urandom_range(2, 4), 16'sd12800, 1'b1, 1'b0);
        check("dc_12800", $signed(out_data), 10000);

        // Impulse response
        do_reset();
        stats_on = 1'b1;
        for (int i = 0; i < 80; i++)
            strobe($urandom_range(2, 4), (i == R - 1) ? 16'sd1280 : 16'sd0, 1'b1, 1'b0);
        stats_on = 1'b0;
        check("impulse_run", st_maxrun, 28);
        check("impulse_nonzero", st_nz, 28);
        check("impulse_peak", st_peak, 750);
        check("impulse_sum", st_sum, 10000);

        // Full-scale DC both polarities
        for (int i = 0; i < 70; i++) strobe($urandom_range(2, 4), -16'sd32768, 1'b1, 1'b0);
        check("dc_neg_full", $signed(out_data), -25600);
        for (int i = 0; i < 70; i++) strobe($urandom_range(2, 4), 16'sd32767, 1'b1, 1'b0);
        check("dc_pos_full", $signed(out_data), 25599);

        // Random samples, occasional missing samples and clears
        for (int i = 0; i < 200; i++)
            strobe($urandom_range(2, 4), IW'($urandom), $urandom_range(0, 7) != 0,
                   $urandom_range(0, 3) == 0);

        // Underflow flag behaviour
        clr_pulse();
        check("uf_clear", underflow, 0);
        for (int i = 0; i < R; i++) strobe(3, 16'sd500, 1'b0, 1'b0);
        check("uf_set", underflow, 1);
        for (int i = 0; i < R; i++) strobe(3, 16'sd500, 1'b0, 1'b1);
        check("uf_set_beats_clr", underflow, 1);
        clr_pulse();
        check("uf_clr_alone", underflow, 0);
        for (int i = 0; i < R; i++) strobe(3, 16'sd500, 1'b0, 1'b0);
        check("uf_set_again", underflow, 1);

        // Reset in the middle of a DC stream
        for (int i = 0; i < 40; i++) strobe($urandom_range(2, 4), 16'sd12800, 1'b1, 1'b0);
        do_reset();
        p0 = instb_pulses;
        for (int i = 0; i < R - 1; i++) strobe(3, 16'sd12800, 1'b1, 1'b0);
        check("no_req_before_10th", instb_pulses - p0, 0);
        strobe(3, 16'sd12800, 1'b1, 1'b0);
        check("req_after_10th", instb_pulses - p0, 1);
        for (int i = 0; i < 60; i++) strobe($urandom_range(2, 4), 16'sd12800, 1'b1, 1'b0);

        repeat (3) @(posedge clock);
        #2;
        check("scoreboard_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
